core_sr_ff_bank: RTL and testbench

- Parametrised multi-channel set/reset flag register with selectable set/clear conflict resolution.
- Adds a synchronous bulk load, registered per-channel rise and fall event pulses, and an any-active summary.
- Has an optional per-channel auto-clear timeout.
- Used for running/busy/valid flag banks in control paths, e.g. one flag per layer or channel in the accelerator sequencers.

---
 rtl/core_sr_ff_bank.sv | 134 +++++++++++++
 tb/tb_core_sr_ff_bank.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sr_ff_bank.sv
// Multi-channel set/reset flag bank with bulk load, registered rise/fall pulses and an any-active summary.
// Optional per-channel auto-clear timeout is enabled by defining CORE_SR_FF_BANK_TIMEOUT_EN.
module core_sr_ff_bank #(
   parameter int unsigned         CHANNELS  = 8,
   parameter int unsigned         PRIORITY  = 0,
   parameter logic [CHANNELS-1:0] RESET_VAL = '0,
   parameter int unsigned         TIMEOUT_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [CHANNELS-1:0]  set_i,
   input  logic [CHANNELS-1:0]  srst_i,
   input  logic                 load_i,
   input  logic [CHANNELS-1:0]  load_data_i,
   input  logic [TIMEOUT_W-1:0] timeout_i,
   output logic [CHANNELS-1:0]  data_o,
   output logic [CHANNELS-1:0]  rise_o,
   output logic [CHANNELS-1:0]  fall_o,
   output logic [CHANNELS-1:0]  expired_o,
   output logic                 any_o,
   input  logic                 assert_on_i
);

   logic [CHANNELS-1:0] r_data;
   logic [CHANNELS-1:0] r_rise;
   logic [CHANNELS-1:0] r_fall;
   logic [CHANNELS-1:0] w_nxt;
   logic [CHANNELS-1:0] w_arm;
   logic [CHANNELS-1:0] w_act;
   logic [CHANNELS-1:0] w_expire;

   // Any explicit request on a channel blocks expiry on that cycle.
   assign w_act = set_i | srst_i | {CHANNELS{load_i}};

   // w_arm marks channels whose new high value comes from set, load or toggle.
   always_comb begin
      w_nxt = r_data;
      w_arm = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (load_i) begin
            w_nxt[k] = load_data_i[k];
            w_arm[k] = load_data_i[k];
         end else if (set_i[k] && srst_i[k]) begin
            case (PRIORITY)
               0: begin
                  w_nxt[k] = 1'b1;
                  w_arm[k] = 1'b1;
               end
               1: w_nxt[k] = 1'b0;
               2: begin
                  w_nxt[k] = ~r_data[k];
                  w_arm[k] = ~r_data[k];
               end
               default: w_nxt[k] = r_data[k];
            endcase
         end else if (set_i[k]) begin
            w_nxt[k] = 1'b1;
            w_arm[k] = 1'b1;
         end else if (srst_i[k]) begin
            w_nxt[k] = 1'b0;
         end else begin
            w_nxt[k] = r_data[k] & ~w_expire[k];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data <= RESET_VAL;
         r_rise <= '0;
         r_fall <= '0;
      end else begin
         r_data <= w_nxt;
         r_rise <= w_nxt & ~r_data;
         r_fall <= ~w_nxt & r_data;
      end
   end

`ifdef CORE_SR_FF_BANK_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] r_cnt [CHANNELS];
   logic [CHANNELS-1:0]  r_expired;

   always_comb begin
      w_expire = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         w_expire[k] = r_data[k] && (r_cnt[k] == TIMEOUT_W'(1)) && !w_act[k];
      end
   end

   // A count of zero never reaches one, so timeout_i=0 disables the auto-clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < CHANNELS; k++) begin
            r_cnt[k] <= '0;
         end
         r_expired <= '0;
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (w_arm[k]) begin
               r_cnt[k] <= timeout_i;
            end else if (w_expire[k]) begin
               r_cnt[k] <= '0;
            end else if (r_data[k] && (r_cnt[k] > TIMEOUT_W'(1))) begin
               r_cnt[k] <= r_cnt[k] - TIMEOUT_W'(1);
            end
         end
         r_expired <= w_expire;
      end
   end

   assign expired_o = r_expired;
`else
   logic w_unused_timeout;

   assign w_expire         = '0;
   assign expired_o        = '0;
   assign w_unused_timeout = ^timeout_i;
`endif

   always_ff @(posedge clk_i) begin
      if (assert_on_i && rst_ni && (PRIORITY < 2)) begin
         for (int k = 0; k < CHANNELS; k++) begin
            assert (!(set_i[k] && srst_i[k]))
               else $error("core_sr_ff_bank: set/clear conflict on channel %0d", k);
         end
      end
   end

   assign data_o = r_data;
   assign rise_o = r_rise;
   assign fall_o = r_fall;
   assign any_o  = |r_data;

endmodule

// File: tb/tb_core_sr_ff_bank.sv
// Scoreboard bench for core_sr_ff_bank: four instances (PRIORITY 0..3) share stimulus and are
// checked against a deadline-based reference model; timeout checks follow CORE_SR_FF_BANK_TIMEOUT_EN.
module tb_core_sr_ff_bank;

`ifdef CORE_SR_FF_BANK_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif
   localparam logic [7:0] RV = 8'hA5;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [7:0] set_i = '0;
   logic [7:0] srst_i = '0;
   logic       load_i = 1'b0;
   logic [7:0] load_data_i = '0;
   logic [7:0] timeout_i = '0;
   logic       assert_on_i = 1'b0;
   logic [7:0] data_o    [4];
   logic [7:0] rise_o    [4];
   logic [7:0] fall_o    [4];
   logic [7:0] expired_o [4];
   logic       any_o     [4];

   always #5 clk_i = ~clk_i;

   for (genvar p = 0; p < 4; p++) begin : g_dut
      core_sr_ff_bank #(
         .CHANNELS (8),
         .PRIORITY (p),
         .RESET_VAL(RV),
         .TIMEOUT_W(8)
      ) u_dut (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .set_i      (set_i),
         .srst_i     (srst_i),
         .load_i     (load_i),
         .load_data_i(load_data_i),
         .timeout_i  (timeout_i),
         .data_o     (data_o[p]),
         .rise_o     (rise_o[p]),
         .fall_o     (fall_o[p]),
         .expired_o  (expired_o[p]),
         .any_o      (any_o[p]),
         .assert_on_i(assert_on_i)
      );
   end

   typedef struct {
      logic [3:0][7:0] d;
      logic [3:0][7:0] r;
      logic [3:0][7:0] f;
      logic [3:0][7:0] e;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference state: flag value and absolute edge index at which an armed timeout is due (-1 none).
   bit   m_flag [4][8];
   int   m_dl   [4][8];
   int   n_edge = 0;

   function automatic void model_reset();
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < 8; k++) begin
            m_flag[p][k] = RV[k];
            m_dl[p][k]   = -1;
         end
      end
   endfunction

   function automatic exp_t model_step(input logic [7:0] s, input logic [7:0] c, input logic l,
                                       input logic [7:0] ld, input int to);
      exp_t x;
      n_edge++;
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < 8; k++) begin
            bit old, nv, act, arm, due, ex;
            old = m_flag[p][k];
            nv  = old;
            act = 1'b1;
            arm = 1'b0;
            if (l) begin
               nv  = ld[k];
               arm = nv;
            end else if (s[k] && c[k]) begin
               case (p)
                  0: begin nv = 1'b1; arm = 1'b1; end
                  1: nv = 1'b0;
                  2: begin nv = !old; arm = nv; end
                  default: nv = old;
               endcase
            end else if (s[k]) begin
               nv  = 1'b1;
               arm = 1'b1;
            end else if (c[k]) begin
               nv = 1'b0;
            end else begin
               act = 1'b0;
            end
            due = !act && old && (m_dl[p][k] >= 0) && (n_edge >= m_dl[p][k]);
            ex  = due && TIMEOUT_ON;
            if (ex) nv = 1'b0;
            if (arm) m_dl[p][k] = (to == 0) ? -1 : n_edge + to;
            m_flag[p][k] = nv;
            x.d[p][k] = nv;
            x.r[p][k] = nv && !old;
            x.f[p][k] = !nv && old;
            x.e[p][k] = ex;
         end
      end
      return x;
   endfunction

   task automatic chk(input string nm, input int p, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, p, $time, act, exp);
      end
   endtask

   // Drive inputs now and queue the response expected after the next rising edge.
   task automatic apply(input logic [7:0] s, input logic [7:0] c, input logic l,
                        input logic [7:0] ld, input logic [7:0] to);
      set_i       = s;
      srst_i      = c;
      load_i      = l;
      load_data_i = ld;
      timeout_i   = to;
      exp_q.push_back(model_step(s, c, l, ld, int'(to)));
   endtask

   task automatic step(input logic [7:0] s, input logic [7:0] c, input logic l,
                       input logic [7:0] ld, input logic [7:0] to);
      @(negedge clk_i);
      apply(s, c, l, ld, to);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, 1'b0, '0, '0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int p = 0; p < 4; p++) begin
               chk("data", p, data_o[p], e.d[p]);
               chk("rise", p, rise_o[p], e.r[p]);
               chk("fall", p, fall_o[p], e.f[p]);
               chk("expired", p, expired_o[p], e.e[p]);
               chk("any", p, {7'b0, any_o[p]}, {7'b0, |e.d[p]});
            end
         end
      end
   end

   initial begin : stim
      logic [7:0] s, c, ld;
      logic [3:0] c1, c2;
      logic       l;
      model_reset();
      rst_ni = 1'b0;
      #12;
      for (int p = 0; p < 4; p++) begin
         chk("rst_data", p, data_o[p], RV);
         chk("rst_any", p, {7'b0, any_o[p]}, 8'h01);
         chk("rst_rise", p, rise_o[p], 8'h00);
         chk("rst_fall", p, fall_o[p], 8'h00);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      apply('0, '0, 1'b0, '0, '0);
      idle(2);

      // Conflict on channel 0 starting from a cleared flag.
      c1 = 4'b0101;
      c2 = 4'b0001;
      step('0, 8'h01, 1'b0, '0, '0);
      step(8'h01, 8'h01, 1'b0, '0, '0);
      @(posedge clk_i);
      #2;
      for (int p = 0; p < 4; p++) chk("conflict1", p, {7'b0, data_o[p][0]}, {7'b0, c1[p]});
      step(8'h01, 8'h01, 1'b0, '0, '0);
      @(posedge clk_i);
      #2;
      for (int p = 0; p < 4; p++) chk("conflict2", p, {7'b0, data_o[p][0]}, {7'b0, c2[p]});
      step('0, 8'hFF, 1'b0, '0, '0);

      // Single rise, silent re-set, single fall on channel 3.
      assert_on_i = 1'b1;
      step(8'h08, '0, 1'b0, '0, '0);
      @(posedge clk_i);
      #2;
      for (int p = 0; p < 4; p++) chk("edge_rise", p, rise_o[p], 8'h08);
      idle(1);
      step(8'h08, '0, 1'b0, '0, '0);
      idle(1);
      step('0, 8'h08, 1'b0, '0, '0);
      idle(1);
      assert_on_i = 1'b0;

      // Load overrides set.
      step('0, '0, 1'b1, 8'h0F, '0);
      step(8'hFF, '0, 1'b1, 8'hF0, '0);
      @(posedge clk_i);
      #2;
      for (int p = 0; p < 4; p++) begin
         chk("load_data", p, data_o[p], 8'hF0);
         chk("load_rise", p, rise_o[p], 8'hF0);
         chk("load_fall", p, fall_o[p], 8'h0F);
      end

      // Timeout: plain expiry, restart on cycle 3, then timeout 0.
      step('0, 8'hFF, 1'b0, '0, '0);
      step(8'h02, '0, 1'b0, '0, 8'd4);
      idle(6);
      step(8'h02, '0, 1'b0, '0, 8'd4);
      idle(2);
      step(8'h02, '0, 1'b0, '0, 8'd4);
      idle(8);
      step(8'h02, '0, 1'b0, '0, 8'd0);
      idle(10);
      step('0, 8'h02, 1'b0, '0, '0);

      for (int i = 0; i < 800; i++) begin
         for (int k = 0; k < 8; k++) begin
            s[k] = ($urandom_range(7) == 0);
            c[k] = ($urandom_range(11) == 0);
         end
         l  = ($urandom_range(39) == 0);
         ld = 8'($urandom);
         step(s, c, l, ld, 8'($urandom_range(6)));
      end

      // Reset in the middle of a running count.
      step('0, 8'hFF, 1'b0, '0, '0);
      step(8'h02, '0, 1'b0, '0, 8'd10);
      idle(5);
      @(posedge clk_i);
      #3;
      rst_ni = 1'b0;
      set_i  = '0;
      srst_i = '0;
      load_i = 1'b0;
      model_reset();
      #1;
      for (int p = 0; p < 4; p++) chk("midrst_data", p, data_o[p], RV);
      @(negedge clk_i);
      rst_ni = 1'b1;
      apply('0, '0, 1'b0, '0, '0);
      idle(14);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_i);
      #3;
      if (exp_q.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
